// File: rtl/alu_pkg.sv
// Shared definitions for the alu and its round-robin front end: opcodes,
// arbiter state encoding and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_NEG   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// Combinational 8-bit alu: AND/OR/ADD/SUB with {negative, carry, zero} flags.
// Opcodes outside the supported set return y=0 and all flags clear.
module alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   ctrl,
  output logic [W-1:0] y,
  output logic [2:0]   flags
);

  logic [W:0] sum_ext;
  logic [W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Carry on SUB is the borrow out, which also equals unsigned a<b.
  always_comb begin
    y     = '0;
    flags = 3'b000;
    case (ctrl)
      OP_AND: begin
        y               = a & b;
        flags[FLG_ZERO] = (y == '0);
      end
      OP_OR: begin
        y               = a | b;
        flags[FLG_ZERO] = (y == '0);
      end
      OP_ADD: begin
        y                = sum_ext[W-1:0];
        flags[FLG_CARRY] = sum_ext[W];
        flags[FLG_ZERO]  = (y == '0);
      end
      OP_SUB: begin
        y                = diff_ext[W-1:0];
        flags[FLG_CARRY] = diff_ext[W];
        flags[FLG_NEG]   = diff_ext[W];
        flags[FLG_ZERO]  = (y == '0);
      end
      default: begin
        y     = '0;
        flags = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one alu between two valid/ready requesters.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the result.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIRST_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_y,
  output logic [2:0]        rsp0_flags,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_y,
  output logic [2:0]        rsp1_flags
);

  localparam logic FIRST_BIT = (FIRST_PRIO != 0);

  state_t            state;
  state_t            state_next;
  logic              prio;
  logic              owner;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [2:0]        op_ctrl;
  logic [DATA_W-1:0] alu_y;
  logic [2:0]        alu_flags;
  logic              accept;
  logic              grant_id;
  logic              rsp_take;

  alu #(.W(DATA_W)) u_alu (
    .a     (op_a),
    .b     (op_b),
    .ctrl  (op_ctrl),
    .y     (alu_y),
    .flags (alu_flags)
  );

  // A lone valid wins outright; on a tie the pointer side wins. Gating with
  // rst_n keeps both readies low while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && state == IDLE) begin
      req0_ready = req0_valid && (!req1_valid || !prio);
      req1_ready = req1_valid && (!req0_valid || prio);
    end
  end

  assign accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign grant_id = req1_ready;
  assign rsp_take = owner ? rsp1_ready : rsp0_ready;

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operands are sampled only at the handshake; the pointer then flips to
  // the requester that lost (or did not ask) this round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= FIRST_BIT;
      owner   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_ctrl <= 3'b000;
    end else if (accept) begin
      prio    <= !grant_id;
      owner   <= grant_id;
      op_a    <= grant_id ? req1_a : req0_a;
      op_b    <= grant_id ? req1_b : req0_b;
      op_ctrl <= grant_id ? req1_ctrl : req0_ctrl;
    end
  end

  // Only the owner's response registers change; the other side keeps its
  // last result, qualified solely by its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_y     <= '0;
      rsp0_flags <= 3'b000;
      rsp1_y     <= '0;
      rsp1_flags <= 3'b000;
    end else if (state == EXEC) begin
      if (owner) begin
        rsp1_y     <= alu_y;
        rsp1_flags <= alu_flags;
      end else begin
        rsp0_y     <= alu_y;
        rsp0_flags <= alu_flags;
      end
    end
  end

endmodule
